// File: rtl/divider_pkg.sv
// Shared constants and enums for the multi-cycle integer divider.
// Operation codes follow RISC-V funct3[1:0] for the M-extension divide ops.
package divider_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/divider_adder.sv
// Ripple-style N-bit adder/subtractor; i_control = 1 computes i_a - i_b.
// In subtract mode o_carry = 1 means no borrow (i_a >= i_b, unsigned).
module divider_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_control,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N-1:0] w_b_eff;

    assign w_b_eff            = i_b ^ {N{i_control}};
    assign {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, w_b_eff} + {{N{1'b0}}, i_control};

endmodule

// File: rtl/divider.sv
// Restoring radix-2 divider: one quotient bit per BUSY cycle on magnitudes,
// with sign fix-up at the end; divide-by-zero and overflow resolve immediately.
module divider
    import divider_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    div_state_t   r_state;
    div_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [N-1:0] r_rem;
    logic [N-1:0] r_quo;
    logic [N-1:0] r_dvs;
    logic [N-1:0] r_result;
    logic         r_is_rem;
    logic         r_neg_q;
    logic         r_neg_r;

    div_op_t      w_op;
    logic         w_accept;
    logic         w_signed;
    logic         w_is_rem;
    logic         w_div_zero;
    logic         w_ovf;
    logic         w_special;
    logic [N-1:0] w_abs_a;
    logic [N-1:0] w_abs_b;
    logic [N-1:0] w_special_res;
    logic [N-1:0] w_rem_sh;
    logic [N-1:0] w_diff;
    logic         w_carry;
    logic         w_take;
    logic [N-1:0] w_rem_nxt;
    logic [N-1:0] w_quo_nxt;
    logic [N-1:0] w_final;
    logic         w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

    assign w_op       = div_op_t'(op);
    assign w_accept   = in_valid && in_ready;
    assign w_signed   = (w_op == DIV) || (w_op == REM);
    assign w_is_rem   = (w_op == REM) || (w_op == REMU);
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
    assign w_special  = w_div_zero || w_ovf;

    assign w_abs_a = (w_signed && dividend[N-1]) ? -dividend : dividend;
    assign w_abs_b = (w_signed && divisor[N-1])  ? -divisor  : divisor;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = w_is_rem ? dividend : '1;
        else
            w_special_res = w_is_rem ? '0 : dividend;
    end

    // A set MSB shifted out of rem means the shifted value exceeds any N-bit divisor.
    assign w_rem_sh  = {r_rem[N-2:0], r_quo[N-1]};
    assign w_take    = w_carry || r_rem[N-1];
    assign w_rem_nxt = w_take ? w_diff : w_rem_sh;
    assign w_quo_nxt = {r_quo[N-2:0], w_take};
    assign w_last    = (r_cnt == CW'(N-1));

    divider_adder #(.N(N)) u_trial_sub (
        .i_a       (w_rem_sh),
        .i_b       (r_dvs),
        .i_control (1'b1),
        .o_sum     (w_diff),
        .o_carry   (w_carry)
    );

    always_comb begin
        w_final = '0;
        if (r_is_rem)
            w_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;
        else
            w_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : BUSY;
            BUSY:    if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_accept) begin
                r_cnt <= '0;
                if (w_special) r_result <= w_special_res;
            end else if (r_state == BUSY) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) r_result <= w_final;
            end
        end
    end

    // Iteration datapath: loaded on acceptance, stepped while BUSY.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_accept) begin
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_signed && (dividend[N-1] ^ divisor[N-1]);
            r_neg_r  <= w_signed && dividend[N-1];
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (N = 32): directed vectors, corner sequences
// and randomized requests compared against a plain-arithmetic reference.
module tb_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_res(input logic [1:0] o, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic sgn;
        logic rem;
        sgn = (o == 2'b00) || (o == 2'b10);
        rem = o[1];
        if (b == 0) return rem ? a : {N{1'b1}};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
        if (sgn) return rem ? N'($signed(a) % $signed(b)) : N'($signed(a) / $signed(b));
        return rem ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [N-1:0] a,
                                   input logic [N-1:0] b);
        logic sgn;
        sgn = (o == 2'b00) || (o == 2'b10);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return N + 1;
    endfunction

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic recover();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one request from IDLE, return result and cycles from acceptance to out_valid.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] res, output int lat);
        op = o; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom; divisor = $urandom; op = 2'($urandom);
        wait_done(lat);
        res = result;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_in_ready_after_hs"}, N'(in_ready), 1);
        if (!in_ready) recover();
    endtask

    initial begin
        logic [N-1:0] res;
        logic [N-1:0] held;
        logic [1:0]   o;
        logic [N-1:0] a, b;
        int           lat;
        int           stable_bad;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; dividend = '0; divisor = '0;

        tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        tbl[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        tbl[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        tbl[6]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        tbl[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        tbl[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        tbl[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        tbl[10] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33};
        tbl[11] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          33};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  N'(in_ready),  1);
        chk("reset_out_valid", N'(out_valid), 0);
        chk("reset_result",    result,        0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), N'(lat), N'(tbl[i].lat));
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: result held and no new acceptance while out_ready stays low.
        run_op(2'b01, 32'd1000, 32'd9, res, lat);
        held = res;
        chk("bp_result", res, 32'd111);
        stable_bad = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable_bad++;
        end
        in_valid = 1'b0;
        chk("bp_hold_violations", N'(stable_bad), 0);
        handshake("bp");

        // Reset five cycles into BUSY discards the operation.
        run_op(2'b01, 32'd1000, 32'd3, res, lat);
        recover();
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", N'(out_valid), 0);
        chk("midrst_in_ready",  N'(in_ready),  1);
        run_op(2'b01, 32'd9, 32'd3, res, lat);
        chk("midrst_next_result", res, 32'd3);
        handshake("midrst");

        // Back-to-back with in_valid held high and operands scrambled while busy.
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? N'($urandom_range(1, 20)) : $urandom >> $urandom_range(0, 31);
            chk($sformatf("b2b%0d_in_ready", i), N'(in_ready), 1);
            op = o; dividend = a; divisor = b;
            @(posedge clk); #1;
            op = 2'($urandom); dividend = $urandom; divisor = $urandom;
            wait_done(lat);
            chk($sformatf("b2b%0d_result", i), result, ref_res(o, a, b));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (!in_ready) recover();

        // Randomized requests against the reference.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                2:       b = '1;
                3:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(o, a, b, res, lat);
            chk($sformatf("rnd%0d_op%0d_%08h_%08h", i, o, a, b), res, ref_res(o, a, b));
            chk($sformatf("rnd%0d_latency", i), N'(lat), N'(ref_lat(o, a, b)));
            handshake($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
